// File: rtl/bit_frame_summarizer.sv
// Per-frame statistics over a stream of scanned bits: ones count, first/last set
// index, longest run of ones, parity and sequence errors, one registered summary per frame.
module bit_frame_summarizer #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ones_count,
    output logic [IDX_W-1:0] first_one,
    output logic [IDX_W-1:0] last_one,
    output logic [CNT_W-1:0] max_run,
    output logic             any_one,
    output logic             parity,
    output logic             seq_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0] r_exp_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_first;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_cur_run;
    logic             r_any;
    logic             r_par;
    logic             r_err;

    logic             w_accept;
    logic             w_at_end;
    logic             w_close;
    logic             w_release;
    logic [CNT_W-1:0] w_cnt;
    logic [IDX_W-1:0] w_first;
    logic [IDX_W-1:0] w_last;
    logic [CNT_W-1:0] w_run;
    logic [CNT_W-1:0] w_max;
    logic             w_any;
    logic             w_par;
    logic             w_err;

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == REPORT);

    // Frame totals including the beat currently on the input.
    always_comb begin
        w_accept  = in_valid && (r_state == COLLECT);
        w_at_end  = (r_exp_idx == IDX_W'(WIDTH - 1));
        w_close   = w_accept && (in_last || w_at_end);
        w_release = (r_state == REPORT) && out_ready;
        w_cnt     = r_cnt;
        w_first   = r_first;
        w_last    = r_last;
        w_run     = '0;
        w_max     = r_max;
        w_any     = r_any;
        w_par     = r_par;
        w_err     = r_err || (in_index != r_exp_idx) || (in_last != w_at_end);
        if (in_bit) begin
            w_cnt  = r_cnt + CNT_W'(1);
            w_last = in_index;
            w_run  = r_cur_run + CNT_W'(1);
            w_any  = 1'b1;
            w_par  = ~r_par;
            if (!r_any) begin
                w_first = in_index;
            end
            if (w_run > r_max) begin
                w_max = w_run;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            COLLECT: if (w_close)   w_next = REPORT;
            REPORT:  if (out_ready) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    // Running accumulators; cleared when the summary is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_idx <= '0;
            r_cnt     <= '0;
            r_first   <= '0;
            r_last    <= '0;
            r_max     <= '0;
            r_cur_run <= '0;
            r_any     <= 1'b0;
            r_par     <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_release) begin
            r_exp_idx <= '0;
            r_cnt     <= '0;
            r_first   <= '0;
            r_last    <= '0;
            r_max     <= '0;
            r_cur_run <= '0;
            r_any     <= 1'b0;
            r_par     <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_exp_idx <= r_exp_idx + IDX_W'(1);
            r_cnt     <= w_cnt;
            r_first   <= w_first;
            r_last    <= w_last;
            r_max     <= w_max;
            r_cur_run <= w_run;
            r_any     <= w_any;
            r_par     <= w_par;
            r_err     <= w_err;
        end
    end

    // Summary registers: loaded only when a frame closes, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_count <= '0;
            first_one  <= '0;
            last_one   <= '0;
            max_run    <= '0;
            any_one    <= 1'b0;
            parity     <= 1'b0;
            seq_err    <= 1'b0;
        end else if (w_close) begin
            ones_count <= w_cnt;
            first_one  <= w_first;
            last_one   <= w_last;
            max_run    <= w_max;
            any_one    <= w_any;
            parity     <= w_par;
            seq_err    <= w_err;
        end
    end

endmodule

// File: tb/tb_bit_frame_summarizer.sv
// Directed and randomized frames checked against a list-based frame model.
module tb_bit_frame_summarizer;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int MAXB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ones_count;
    logic [IDX_W-1:0] first_one;
    logic [IDX_W-1:0] last_one;
    logic [CNT_W-1:0] max_run;
    logic             any_one;
    logic             parity;
    logic             seq_err;

    bit_frame_summarizer #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
        .in_bit(in_bit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .ones_count(ones_count), .first_one(first_one), .last_one(last_one),
        .max_run(max_run), .any_one(any_one), .parity(parity), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt, first, last, maxr, any, par, err, used;
    } summ_t;

    int n_vec = 0;
    int n_err = 0;
    int b_idx [MAXB];
    int b_bit [MAXB];
    int b_last[MAXB];
    int n_beats;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame model: walk the beat list until an explicit or implicit last.
    task automatic model(output summ_t s);
        int run;
        s = '{default: 0};
        run = 0;
        for (int k = 0; k < n_beats; k++) begin
            s.used = k + 1;
            if (b_idx[k] != k) s.err = 1;
            if (b_bit[k] != 0) begin
                if (s.cnt == 0) s.first = b_idx[k];
                s.cnt++;
                s.last = b_idx[k];
                run++;
                if (run > s.maxr) s.maxr = run;
            end else begin
                run = 0;
            end
            if ((b_last[k] != 0) != (k == WIDTH - 1)) s.err = 1;
            if (b_last[k] != 0 || k == WIDTH - 1) break;
        end
        s.any = (s.cnt > 0) ? 1 : 0;
        s.par = s.cnt % 2;
    endtask

    task automatic load_bits(input int pattern, input int n);
        n_beats = n;
        for (int k = 0; k < n; k++) begin
            b_idx[k]  = k;
            b_bit[k]  = (pattern >> k) & 1;
            b_last[k] = (k == n - 1) ? 1 : 0;
        end
    endtask

    task automatic send_beats(input int cnt, input int gap_pct);
        for (int k = 0; k < cnt; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("in_ready_beat", 32'(in_ready), 1);
            in_valid = 1'b1;
            in_index = IDX_W'(b_idx[k]);
            in_bit   = b_bit[k] != 0;
            in_last  = b_last[k] != 0;
            @(posedge clk);
        end
    endtask

    task automatic check_fields(input string tag, input summ_t s);
        chk({tag, ".ones_count"}, 32'(ones_count), s.cnt);
        chk({tag, ".first_one"},  32'(first_one),  s.first);
        chk({tag, ".last_one"},   32'(last_one),   s.last);
        chk({tag, ".max_run"},    32'(max_run),    s.maxr);
        chk({tag, ".any_one"},    32'(any_one),    s.any);
        chk({tag, ".parity"},     32'(parity),     s.par);
        chk({tag, ".seq_err"},    32'(seq_err),    s.err);
    endtask

    // Send a frame, then check the summary, optionally stalling the output side.
    task automatic run_frame(input string tag, input int gap_pct, input int hold, input bit hold_valid);
        summ_t s;
        model(s);
        send_beats(s.used, gap_pct);
        @(negedge clk);
        in_valid = hold_valid;
        in_index = '0;
        in_bit   = 1'b1;
        in_last  = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 1);
        chk({tag, ".in_ready_rep"}, 32'(in_ready), 0);
        check_fields(tag, s);
        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 1);
            chk({tag, ".hold_ready"}, 32'(in_ready), 0);
            chk({tag, ".hold_cnt"}, 32'(ones_count), s.cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid_drop"}, 32'(out_valid), 0);
        chk({tag, ".in_ready_back"}, 32'(in_ready), 1);
        check_fields({tag, ".kept"}, s);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        summ_t s;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.out_valid", 32'(out_valid), 0);
        s = '{default: 0};
        check_fields("rst", s);
        @(negedge clk);
        rst_n = 1'b1;

        // 1011001001 written bit0 first: bits 0,2,3,6,9 set.
        load_bits(32'h24D, WIDTH);
        run_frame("frame1", 0, 0, 1'b0);
        chk("frame1.one_cycle", 32'(out_valid), 0);

        load_bits(0, WIDTH);
        run_frame("zeros", 0, 0, 1'b0);

        load_bits(32'h3FF, WIDTH);
        run_frame("ones_hold", 0, 5, 1'b1);

        // A clean frame right after proves the held beat was not consumed.
        load_bits(32'h155, WIDTH);
        run_frame("after_hold", 0, 0, 1'b0);

        load_bits(32'h0F3, WIDTH);
        for (int k = 2; k < WIDTH; k++) b_idx[k] = k + 1;
        run_frame("idx_skip", 0, 0, 1'b0);

        load_bits(32'h1B, 5);
        run_frame("early_last", 0, 0, 1'b0);

        // Missing last on the final index closes the frame implicitly.
        load_bits(32'h3A5, WIDTH + 2);
        for (int k = 0; k < n_beats; k++) b_last[k] = 0;
        run_frame("no_last", 0, 0, 1'b0);

        load_bits(32'h24D, WIDTH);
        run_frame("gaps", 40, 0, 1'b0);

        load_bits(32'h3FF, WIDTH);
        send_beats(6, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        s = '{default: 0};
        check_fields("async_rst", s);
        chk("async_rst.in_ready", 32'(in_ready), 1);
        chk("async_rst.out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 0, 0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            n_beats = WIDTH + 2;
            for (int k = 0; k < n_beats; k++) begin
                b_idx[k]  = ($urandom_range(99) < 8) ? int'($urandom_range(15)) : k;
                b_bit[k]  = int'($urandom_range(1));
                b_last[k] = (k == WIDTH - 1) ? int'($urandom_range(99) < 80)
                                             : int'($urandom_range(99) < 6);
            end
            run_frame("rand", 25, int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
